video_stream_gen: RTL and testbench
===================================

Name: video_stream_gen

Overview:
- Camera-side transmitter of the DVP-style stream the Sobel pipeline consumes.
- Emits vsync/href framing and registered RGB565 pixels with programmable blanking and selectable synthetic patterns.
- Used as on-chip camera replacement for bring-up and as the stimulus source in pipeline benches; its outputs connect directly to the pipeline's href, vsync and pixel_in.

Parameters:
- IMG_WIDTH, 640, active pixels per line (>=2)
- IMG_HEIGHT, 480, active lines per frame (>=1)
- H_BLANK, 160, blank cycles after the active region of every line (>=1)
- VSYNC_LINES, 3, lines with vsync high at frame start (>=1)
- VBP_LINES, 17, blank lines after vsync, before the first active line (>=0)
- VFP_LINES, 10, blank lines after the last active line (>=0)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run request; sampled only at frame boundaries
- pattern_sel  input  2  00 solid white, 01 horizontal gradient, 10 checkerboard, 11 vertical step edge
- vsync  output  1  frame sync, high for the VSYNC_LINES lines
- href  output  1  high during active pixels
- pixel_out  output  16  RGB565 pixel; 16'h0000 whenever href=0
- frame_done  output  1  one-cycle pulse on the last cycle of each frame
- frame_count  output  8  completed-frame counter

Behaviour:
- Clock and reset: single clock domain. rst_n low forces all outputs to 0, frame_count=0, all counters to 0, state IDLE. This applies immediately, including mid-frame. All outputs are registered.
- Line timing: line length L = IMG_WIDTH + H_BLANK cycles. col counts 0..L-1 and wraps. The line counter advances when col wraps.
- States:
  - IDLE: all outputs 0. If enable=1 on a clock edge, go to VSYNC; vsync is high on the following cycle, with col=0 and line=0.
  - VSYNC: VSYNC_LINES*L cycles with vsync=1, href=0.
  - VBP: VBP_LINES*L cycles, all low. Skipped if VBP_LINES=0.
  - ACTIVE: IMG_HEIGHT lines. href=1 for col 0..IMG_WIDTH-1, then 0 for H_BLANK cycles. row counts 0..IMG_HEIGHT-1.
  - VFP: VFP_LINES*L cycles, all low. Skipped if VFP_LINES=0.
- Frame end and frame_done: frame_done=1 on the last cycle of the frame (last cycle of VFP, or of the last ACTIVE line when VFP_LINES=0).
  - frame_count increments on that cycle and wraps 255 to 0.
  - On that cycle, if enable=1, the next frame starts with no gap (vsync=1 next cycle). Otherwise return to IDLE.
- enable deassertion mid-frame has no effect until the frame end; frames always complete.
- pattern_sel is latched at VSYNC entry and held for the whole frame. Changes mid-frame take effect the next frame.
- Pixel patterns (g = 8-bit gray, encoded as {g[7:3], g[7:2], g[7:3]}):
  - 00: 16'hFFFF.
  - 01: g = col[7:0], truncated modulo 256.
  - 10: 16'hFFFF if col[3]^row[3], else 16'h0000.
  - 11: 16'h0000 for col < IMG_WIDTH/2 (integer divide), else 16'hFFFF.
- Frame total: (VSYNC_LINES + VBP_LINES + IMG_HEIGHT + VFP_LINES) * L cycles. href is never high while vsync is high.
- Counter widths: $clog2 of their maximum value +1. No overflow inside a frame.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4, H_BLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, so L=12 and the frame is 84 cycles.
- Reset: hold rst_n=0 with enable=1 -> vsync=href=frame_done=0, pixel_out=0, frame_count=0. Assert rst_n=0 again mid-ACTIVE -> outputs 0 in the same cycle, and the next frame restarts from VSYNC.
- Single frame, pattern 11, enable pulsed 1 cycle in IDLE:
  - vsync high cycles 1-12.
  - 4 href bursts of 8 cycles starting at cycles 25, 37, 49, 61.
  - pixel_out 0000 x4 then FFFF x4 in each burst.
  - frame_done at cycle 84, frame_count=1, then IDLE.
- Back-to-back: hold enable=1 for 3 frames -> vsync rises on the cycle after each frame_done (cycles 85 and 169); frame_count 1, 2, 3.
- Pattern latch: pattern_sel=01, switch to 00 during row 2 -> the frame keeps gradient values 16'h0000, 0000, 0000, 0000, 0020, 0020, 0020, 0020 across cols 0-7 of every row. The next frame is all FFFF.
- Wrap: preload by running 256 frames -> frame_count goes 255 to 0 on the 256th frame_done; frame_done stays a 1-cycle pulse.
- Disable mid-frame: drop enable during VBP -> the frame completes all 4 active lines, frame_done fires, then the block returns to IDLE with vsync staying 0.

Source files
------------

// File: rtl/video_stream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_stream_gen_if
//  Purpose  : DVP-style stream bundle between the generator and its consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface video_stream_gen_if;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        vsync;
    logic        href;
    logic [15:0] pixel_out;
    logic        frame_done;
    logic [7:0]  frame_count;

    // The generator drives the stream; the consumer drives the run controls.
    modport master (
        input  enable,
        input  pattern_sel,
        output vsync,
        output href,
        output pixel_out,
        output frame_done,
        output frame_count
    );

    modport slave (
        output enable,
        output pattern_sel,
        input  vsync,
        input  href,
        input  pixel_out,
        input  frame_done,
        input  frame_count
    );
endinterface
`default_nettype wire

// File: rtl/video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_stream_gen
//  Purpose  : Synthetic camera source emitting vsync/href framing and RGB565
//             test patterns with programmable blanking.
//  Revision : 1.0  initial release
// ============================================================================
module video_stream_gen #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  wire                clk,
    input  wire                rst_n,
    video_stream_gen_if.master vid
);

    localparam int C_LINE_LEN  = IMG_WIDTH + H_BLANK;
    localparam int C_MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int C_MAX_B     = (IMG_HEIGHT > VFP_LINES) ? IMG_HEIGHT : VFP_LINES;
    localparam int C_MAX_LINES = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int COL_W       = $clog2(C_LINE_LEN - 1) + 1;
    localparam int LINE_W      = $clog2(C_MAX_LINES) + 1;

    localparam logic [COL_W-1:0]  C_COL_LAST  = COL_W'(C_LINE_LEN - 1);
    localparam logic [COL_W-1:0]  C_ACT_COLS  = COL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0]  C_HALF_COLS = COL_W'(IMG_WIDTH / 2);
    localparam logic [LINE_W-1:0] C_VS_LAST   = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] C_VBP_LAST  = LINE_W'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
    localparam logic [LINE_W-1:0] C_ACT_LAST  = LINE_W'(IMG_HEIGHT - 1);
    localparam logic [LINE_W-1:0] C_VFP_LAST  = LINE_W'((VFP_LINES > 0) ? VFP_LINES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    // The frame ends in VFP, or in the last active line when there is no front porch.
    localparam state_t            C_LAST_STATE = (VFP_LINES > 0) ? ST_VFP : ST_ACTIVE;
    localparam logic [LINE_W-1:0] C_END_LINE   = (VFP_LINES > 0) ? C_VFP_LAST : C_ACT_LAST;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [1:0]          pat_q, pat_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [15:0]         pixel_q, pixel_d;
    logic                done_q, done_d;
    logic [7:0]          count_q, count_d;

    logic [LINE_W-1:0]   last_line;
    logic                start_frame;
    logic [7:0]          gray;
    logic                col_b3;
    logic                row_b3;

    always_comb begin
        last_line = '0;
        case (state_q)
            ST_VSYNC:  last_line = C_VS_LAST;
            ST_VBP:    last_line = C_VBP_LAST;
            ST_ACTIVE: last_line = C_ACT_LAST;
            ST_VFP:    last_line = C_VFP_LAST;
            default:   last_line = '0;
        endcase
    end

    // Position/state sequencing; enable is only looked at in IDLE and on the frame's last cycle.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        pat_d       = pat_q;
        start_frame = 1'b0;

        if (state_q == ST_IDLE) begin
            start_frame = vid.enable;
        end else if (col_q == C_COL_LAST) begin
            col_d = '0;
            if (line_q == last_line) begin
                line_d = '0;
                case (state_q)
                    ST_VSYNC: state_d = (VBP_LINES > 0) ? ST_VBP : ST_ACTIVE;
                    ST_VBP:   state_d = ST_ACTIVE;
                    ST_ACTIVE: begin
                        if (VFP_LINES > 0) begin
                            state_d = ST_VFP;
                        end else begin
                            state_d     = ST_IDLE;
                            start_frame = vid.enable;
                        end
                    end
                    ST_VFP: begin
                        state_d     = ST_IDLE;
                        start_frame = vid.enable;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                line_d = line_q + LINE_W'(1);
            end
        end else begin
            col_d = col_q + COL_W'(1);
        end

        if (start_frame) begin
            state_d = ST_VSYNC;
            col_d   = '0;
            line_d  = '0;
            pat_d   = vid.pattern_sel;
        end
    end

    // Outputs are derived from the next position so they line up with it once registered.
    always_comb begin
        gray    = 8'(col_d);
        col_b3  = |(col_d & COL_W'(8));
        row_b3  = |(line_d & LINE_W'(8));

        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE) && (col_d < C_ACT_COLS);
        done_d  = (state_d == C_LAST_STATE) && (col_d == C_COL_LAST) && (line_d == C_END_LINE);
        count_d = count_q + {7'd0, done_d};

        pixel_d = 16'h0000;
        if (href_d) begin
            case (pat_d)
                2'b00:   pixel_d = 16'hFFFF;
                2'b01:   pixel_d = {gray[7:3], gray[7:2], gray[7:3]};
                2'b10:   pixel_d = (col_b3 ^ row_b3) ? 16'hFFFF : 16'h0000;
                default: pixel_d = (col_d < C_HALF_COLS) ? 16'h0000 : 16'hFFFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            pat_q   <= 2'b00;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            pixel_q <= 16'h0000;
            done_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            pixel_q <= pixel_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign vid.vsync       = vsync_q;
    assign vid.href        = href_q;
    assign vid.pixel_out   = pixel_q;
    assign vid.frame_done  = done_q;
    assign vid.frame_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_stream_gen
//  Purpose  : Self-checking bench for video_stream_gen using a pixel scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_stream_gen;

    localparam int TB_W     = 8;
    localparam int TB_H     = 4;
    localparam int TB_HB    = 4;
    localparam int TB_VS    = 1;
    localparam int TB_VBP   = 1;
    localparam int TB_VFP   = 1;
    localparam int TB_L     = TB_W + TB_HB;
    localparam int TB_FRAME = (TB_VS + TB_VBP + TB_H + TB_VFP) * TB_L;
    localparam int TB_VS_END    = TB_VS * TB_L;
    localparam int TB_ACT_FIRST = (TB_VS + TB_VBP) * TB_L + 1;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic [15:0] exp_px[$];

    video_stream_gen_if vif ();

    video_stream_gen #(
        .IMG_WIDTH   (TB_W),
        .IMG_HEIGHT  (TB_H),
        .H_BLANK     (TB_HB),
        .VSYNC_LINES (TB_VS),
        .VBP_LINES   (TB_VBP),
        .VFP_LINES   (TB_VFP)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input logic [1:0] pat, input int col, input int row);
        logic [7:0] g;
        case (pat)
            2'b00:   return 16'hFFFF;
            2'b01: begin
                g = col[7:0];
                return {g[7:3], g[7:2], g[7:3]};
            end
            2'b10:   return (col[3] ^ row[3]) ? 16'hFFFF : 16'h0000;
            default: return (col < TB_W / 2) ? 16'h0000 : 16'hFFFF;
        endcase
    endfunction

    task automatic check_zero(input string tag, input logic [7:0] exp_cnt);
        check_val({tag, "_vsync"}, vif.vsync, 0);
        check_val({tag, "_href"}, vif.href, 0);
        check_val({tag, "_pixel"}, vif.pixel_out, 0);
        check_val({tag, "_done"}, vif.frame_done, 0);
        check_val({tag, "_count"}, vif.frame_count, exp_cnt);
    endtask

    task automatic idle_check(input int n, input logic [7:0] exp_cnt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_zero("idle", exp_cnt);
        end
    endtask

    // Follows one frame from its first cycle; the frame starts on the next clock edge.
    task automatic check_frame(input logic [1:0] pat, input logic [7:0] exp_cnt, input int stop_cyc,
                               input int sw_cyc, input logic [1:0] sw_pat,
                               input int en_cyc, input logic en_val);
        int a;
        int col;
        int row;
        logic in_act;
        logic exp_href;
        logic [15:0] exp_pix;
        for (int r = 0; r < TB_H; r++)
            for (int c = 0; c < TB_W; c++)
                exp_px.push_back(ref_pixel(pat, c, r));
        for (int cyc = 1; cyc <= stop_cyc; cyc++) begin
            @(posedge clk); #1;
            if (cyc == sw_cyc) vif.pattern_sel = sw_pat;
            if (cyc == en_cyc) vif.enable = en_val;
            a        = cyc - TB_ACT_FIRST;
            in_act   = (a >= 0) && (a < TB_H * TB_L);
            col      = in_act ? a % TB_L : 0;
            row      = in_act ? a / TB_L : 0;
            exp_href = in_act && (col < TB_W);
            exp_pix  = exp_href ? exp_px.pop_front() : 16'h0000;
            check_val("vsync", vif.vsync, (cyc <= TB_VS_END) ? 1 : 0);
            check_val("href", vif.href, exp_href);
            check_val("pixel", vif.pixel_out, exp_pix);
            check_val("frame_done", vif.frame_done, (cyc == TB_FRAME) ? 1 : 0);
            if (cyc == TB_FRAME - 1) check_val("count_before", vif.frame_count, 8'(exp_cnt - 8'd1));
            if (cyc == TB_FRAME)     check_val("count_after", vif.frame_count, exp_cnt);
        end
        if (stop_cyc == TB_FRAME) check_val("sb_left", exp_px.size(), 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        vif.enable = 1'b1;
        vif.pattern_sel = 2'b11;

        // Reset held with enable high keeps everything quiet.
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst", 8'd0);
        vif.enable = 1'b0;
        rst_n = 1'b1;
        idle_check(4, 8'd0);

        // Single frame, step-edge pattern, one-cycle enable pulse.
        vif.enable = 1'b1;
        check_frame(2'b11, 8'd1, TB_FRAME, 0, 2'b00, 1, 1'b0);
        idle_check(6, 8'd1);

        // Back-to-back frames, enable dropped inside the third.
        vif.pattern_sel = 2'b10;
        vif.enable = 1'b1;
        check_frame(2'b10, 8'd2, TB_FRAME, 0, 2'b00, 0, 1'b0);
        check_frame(2'b10, 8'd3, TB_FRAME, 0, 2'b00, 0, 1'b0);
        check_frame(2'b10, 8'd4, TB_FRAME, 0, 2'b00, 60, 1'b0);
        idle_check(6, 8'd4);

        // Pattern change during row 2 only affects the next frame; that frame loses enable in VBP.
        vif.pattern_sel = 2'b01;
        vif.enable = 1'b1;
        check_frame(2'b01, 8'd5, TB_FRAME, 50, 2'b00, 0, 1'b0);
        check_frame(2'b00, 8'd6, TB_FRAME, 0, 2'b00, 20, 1'b0);
        idle_check(6, 8'd6);

        // Asynchronous reset in the middle of the active region.
        vif.pattern_sel = 2'b10;
        vif.enable = 1'b1;
        check_frame(2'b10, 8'd7, 30, 0, 2'b00, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid", 8'd0);
        exp_px.delete();
        vif.enable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_frame(2'b10, 8'd1, TB_FRAME, 0, 2'b00, 1, 1'b0);
        idle_check(3, 8'd1);

        // Run the counter through its wrap.
        vif.pattern_sel = 2'b01;
        vif.enable = 1'b1;
        for (int f = 0; f < 255; f++)
            check_frame(2'b01, 8'(f + 2), TB_FRAME, 0, 2'b00, (f == 254) ? 1 : 0, 1'b0);
        idle_check(4, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
